// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the UART message arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_msg_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Bit positions of each requester in the grant/pending vectors.
  localparam int SRC_CHANGE  = 3;
  localparam int SRC_CONFIRM = 2;
  localparam int SRC_QUARTER = 1;
  localparam int SRC_DIME    = 0;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int MSG_LEN_CRLF = 6;
  localparam int MSG_LEN_BARE = 4;

  // Nibbles above 9 are deliberately not clamped; they map to ':' .. '?'.
  function automatic logic [7:0] bcd_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/uart_msg_arbiter_prio_pick4.sv
// Fixed-priority one-hot picker over four requests, bit 3 highest.
// Latency: purely combinational.
// Backpressure: none; output is 0 when no request is set.
// Ports: req (4-bit request vector) -> pick (one-hot winner or 0).
module prio_pick4 (
  input  logic [3:0] req,
  output logic [3:0] pick
);

  always_comb begin
    pick = 4'b0000;
    if (req[3])      pick = 4'b1000;
    else if (req[2]) pick = 4'b0100;
    else if (req[1]) pick = 4'b0010;
    else if (req[0]) pick = 4'b0001;
  end

endmodule

// File: rtl/uart_msg_arbiter.sv
// Arbitrates four vending event sources onto one UART byte stream as ASCII
// messages: tag, three BCD digits, optional CR LF.
// Latency: event pulse in N -> pending in N+1 -> tag byte on tx_data in N+2.
// Backpressure: tx_data holds while tx_ready=0 (no timeout); new events
//   coalesce into pending flags, repeats counted in drop_cnt (saturating).
// Ports: clk, reset (sync, active-low); give_change/confirm_uart/
//   quarter_uart/dime_uart event pulses; dabbled BCD balance; tx_ready in;
//   tx_valid/tx_data byte out; busy, grant, pending, drop_cnt status.
module uart_msg_arbiter
  import uart_msg_pkg::*;
#(
  parameter logic [7:0] TAG_CHANGE  = 8'h43,
  parameter logic [7:0] TAG_CONFIRM = 8'h56,
  parameter logic [7:0] TAG_QUARTER = 8'h51,
  parameter logic [7:0] TAG_DIME    = 8'h44,
  parameter bit         SEND_CRLF   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        give_change,
  input  logic        confirm_uart,
  input  logic        quarter_uart,
  input  logic        dime_uart,
  input  logic [11:0] dabbled,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [3:0]  grant,
  output logic [3:0]  pending,
  output logic [7:0]  drop_cnt
);

  localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'(MSG_LEN_CRLF - 1)
                                              : 3'(MSG_LEN_BARE - 1);

  state_t      state, state_nxt;
  logic [3:0]  grant_q, pending_q, events, pick, clr, dropped;
  logic [11:0] snap;
  logic [2:0]  idx;
  logic [7:0]  drop_q, drop_nxt, tag;
  logic [2:0]  n_drop;
  logic [8:0]  drop_sum;
  logic        start, xfer;

  assign events = {give_change, confirm_uart, quarter_uart, dime_uart};

  prio_pick4 u_pick (
    .req  (pending_q),
    .pick (pick)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    clr       = 4'b0000;
    tx_valid  = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending_q != 4'b0000) begin
          start     = 1'b1;
          clr       = pick;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready && (idx == LAST_IDX)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign xfer = tx_valid & tx_ready;

  always_comb begin
    tag = TAG_DIME;
    if (grant_q[SRC_CHANGE])       tag = TAG_CHANGE;
    else if (grant_q[SRC_CONFIRM]) tag = TAG_CONFIRM;
    else if (grant_q[SRC_QUARTER]) tag = TAG_QUARTER;
  end

  always_comb begin
    tx_data = 8'h00;
    if (state == ST_SEND) begin
      case (idx)
        3'd0:    tx_data = tag;
        3'd1:    tx_data = bcd_ascii(snap[11:8]);
        3'd2:    tx_data = bcd_ascii(snap[7:4]);
        3'd3:    tx_data = bcd_ascii(snap[3:0]);
        3'd4:    tx_data = ASCII_CR;
        3'd5:    tx_data = ASCII_LF;
        default: tx_data = 8'h00;
      endcase
    end
  end

  // A repeat only counts as lost if the flag survives this edge; the source
  // being granted right now keeps its new pulse as a fresh request.
  assign dropped  = events & pending_q & ~clr;
  assign n_drop   = {2'b00, dropped[0]} + {2'b00, dropped[1]}
                  + {2'b00, dropped[2]} + {2'b00, dropped[3]};
  assign drop_sum = {1'b0, drop_q} + {6'b000000, n_drop};
  assign drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      grant_q   <= 4'b0000;
      pending_q <= 4'b0000;
      snap      <= 12'h000;
      idx       <= 3'd0;
      drop_q    <= 8'h00;
    end else begin
      state     <= state_nxt;
      pending_q <= (pending_q & ~clr) | events;
      drop_q    <= drop_nxt;
      if (start) begin
        grant_q <= pick;
        snap    <= dabbled;
        idx     <= 3'd0;
      end else if (xfer) begin
        if (idx == LAST_IDX) begin
          grant_q <= 4'b0000;
          idx     <= 3'd0;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

  assign grant    = grant_q;
  assign pending  = pending_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
module tb_uart_msg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        give_change, confirm_uart, quarter_uart, dime_uart;
  logic [11:0] dabbled;
  logic        tx_ready;

  logic       v6, b6, v4, b4;
  logic [7:0] d6, c6, d4, c4;
  logic [3:0] g6, p6, g4, p4;

  always #5 clk = ~clk;

  uart_msg_arbiter #(.SEND_CRLF(1'b1)) dut6 (
    .clk(clk), .reset(reset), .give_change(give_change),
    .confirm_uart(confirm_uart), .quarter_uart(quarter_uart),
    .dime_uart(dime_uart), .dabbled(dabbled), .tx_ready(tx_ready),
    .tx_valid(v6), .tx_data(d6), .busy(b6), .grant(g6), .pending(p6),
    .drop_cnt(c6)
  );

  uart_msg_arbiter #(.SEND_CRLF(1'b0)) dut4 (
    .clk(clk), .reset(reset), .give_change(give_change),
    .confirm_uart(confirm_uart), .quarter_uart(quarter_uart),
    .dime_uart(dime_uart), .dabbled(dabbled), .tx_ready(tx_ready),
    .tx_valid(v4), .tx_data(d4), .busy(b4), .grant(g4), .pending(p4),
    .drop_cnt(c4)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per build (0 = CRLF, 1 = bare), a message is an array of
  // bytes plus a read position; idle when the position reached the length.
  localparam logic [7:0] TAGS [4] = '{8'h44, 8'h51, 8'h56, 8'h43};
  logic [3:0] m_pend  [2];
  logic [3:0] m_grant [2];
  int         m_drop  [2];
  logic [7:0] m_msg   [2][6];
  int         m_len   [2];
  int         m_pos   [2];

  task automatic model_edge(input int k, input logic [3:0] ev, input logic rst_n,
                            input logic [11:0] dab, input logic rdy);
    logic [3:0] clr;
    int s;
    clr = 4'b0000;
    if (!rst_n) begin
      m_pend[k] = 0; m_grant[k] = 0; m_drop[k] = 0; m_len[k] = 0; m_pos[k] = 0;
      return;
    end
    if (m_pos[k] < m_len[k]) begin
      if (rdy) begin
        m_pos[k]++;
        if (m_pos[k] == m_len[k]) m_grant[k] = 0;
      end
    end else if (m_pend[k] != 0) begin
      s = 3;
      while (!m_pend[k][s]) s--;
      clr[s] = 1'b1;
      m_grant[k] = clr;
      m_msg[k][0] = TAGS[s];
      m_msg[k][1] = 8'h30 + {4'h0, dab[11:8]};
      m_msg[k][2] = 8'h30 + {4'h0, dab[7:4]};
      m_msg[k][3] = 8'h30 + {4'h0, dab[3:0]};
      m_msg[k][4] = 8'h0D;
      m_msg[k][5] = 8'h0A;
      m_len[k] = (k == 0) ? 6 : 4;
      m_pos[k] = 0;
    end
    for (int i = 0; i < 4; i++)
      if (ev[i] && m_pend[k][i] && !clr[i] && m_drop[k] < 255) m_drop[k]++;
    m_pend[k] = (m_pend[k] & ~clr) | ev;
  endtask

  task automatic model_cmp(input int k, input logic av, input logic [7:0] ad,
                           input logic ab, input logic [3:0] ag,
                           input logic [3:0] ap, input logic [7:0] ac);
    logic       ev_v;
    logic [7:0] ev_d;
    ev_v = (m_pos[k] < m_len[k]);
    ev_d = ev_v ? m_msg[k][m_pos[k]] : 8'h00;
    chk(k == 0 ? "m6_valid" : "m4_valid", {31'b0, av}, {31'b0, ev_v});
    chk(k == 0 ? "m6_data"  : "m4_data",  {24'b0, ad}, {24'b0, ev_d});
    chk(k == 0 ? "m6_busy"  : "m4_busy",  {31'b0, ab}, {31'b0, ev_v});
    chk(k == 0 ? "m6_grant" : "m4_grant", {28'b0, ag}, {28'b0, m_grant[k]});
    chk(k == 0 ? "m6_pend"  : "m4_pend",  {28'b0, ap}, {28'b0, m_pend[k]});
    chk(k == 0 ? "m6_drop"  : "m4_drop",  {24'b0, ac}, m_drop[k]);
  endtask

  logic [7:0] xfer_log[$];

  // Drive inputs, clock once, advance the model, compare #1 after the edge.
  task automatic step(input logic [3:0] ev, input logic rst_n,
                      input logic [11:0] dab, input logic rdy);
    {give_change, confirm_uart, quarter_uart, dime_uart} = ev;
    reset    = rst_n;
    dabbled  = dab;
    tx_ready = rdy;
    if (rst_n && rdy && v6 === 1'b1) xfer_log.push_back(d6);
    @(posedge clk);
    model_edge(0, ev, rst_n, dab, rdy);
    model_edge(1, ev, rst_n, dab, rdy);
    #1;
    model_cmp(0, v6, d6, b6, g6, p6, c6);
    model_cmp(1, v4, d4, b4, g4, p4, c4);
  endtask

  typedef struct {
    logic [3:0]  ev;
    logic        rst_n;
    logic [11:0] dab;
    logic        rdy;
    logic        x_valid;
    logic [7:0]  x_data;
    logic [3:0]  x_grant;
    logic [3:0]  x_pend;
  } vec_t;

  vec_t vec[9];

  initial begin
    vec[0] = '{4'h0, 1'b0, 12'h135, 1'b1, 1'b0, 8'h00, 4'h0, 4'h0};
    vec[1] = '{4'h2, 1'b1, 12'h135, 1'b1, 1'b0, 8'h00, 4'h0, 4'h2};
    vec[2] = '{4'h0, 1'b1, 12'h135, 1'b1, 1'b1, 8'h51, 4'h2, 4'h0};
    vec[3] = '{4'h0, 1'b1, 12'h135, 1'b1, 1'b1, 8'h31, 4'h2, 4'h0};
    vec[4] = '{4'h0, 1'b1, 12'h135, 1'b1, 1'b1, 8'h33, 4'h2, 4'h0};
    vec[5] = '{4'h0, 1'b1, 12'h135, 1'b1, 1'b1, 8'h35, 4'h2, 4'h0};
    vec[6] = '{4'h0, 1'b1, 12'h135, 1'b1, 1'b1, 8'h0D, 4'h2, 4'h0};
    vec[7] = '{4'h0, 1'b1, 12'h135, 1'b1, 1'b1, 8'h0A, 4'h2, 4'h0};
    vec[8] = '{4'h0, 1'b1, 12'h135, 1'b1, 1'b0, 8'h00, 4'h0, 4'h0};

    {give_change, confirm_uart, quarter_uart, dime_uart} = 4'h0;
    reset = 1'b0; dabbled = 12'h000; tx_ready = 1'b0;

    // Single quarter message, hand-derived expectations.
    for (int i = 0; i < 9; i++) begin
      step(vec[i].ev, vec[i].rst_n, vec[i].dab, vec[i].rdy);
      chk("tbl_valid", {31'b0, v6}, {31'b0, vec[i].x_valid});
      chk("tbl_busy",  {31'b0, b6}, {31'b0, vec[i].x_valid});
      chk("tbl_data",  {24'b0, d6}, {24'b0, vec[i].x_data});
      chk("tbl_grant", {28'b0, g6}, {28'b0, vec[i].x_grant});
      chk("tbl_pend",  {28'b0, p6}, {28'b0, vec[i].x_pend});
    end
    chk("tbl_drop", {24'b0, c6}, 32'd0);

    // Simultaneous change/quarter/dime: served C, Q, D with no drops.
    xfer_log.delete();
    step(4'b1011, 1'b1, 12'h208, 1'b1);
    for (int i = 0; i < 25; i++) step(4'h0, 1'b1, 12'h208, 1'b1);
    chk("simul_len", xfer_log.size(), 32'd18);
    if (xfer_log.size() == 18) begin
      chk("simul_tag0", {24'b0, xfer_log[0]},  32'h43);
      chk("simul_tag1", {24'b0, xfer_log[6]},  32'h51);
      chk("simul_tag2", {24'b0, xfer_log[12]}, 32'h44);
    end
    chk("simul_drop", {24'b0, c6}, 32'd0);

    // Stall ten cycles while the tens digit is on the bus.
    step(4'b0010, 1'b1, 12'h135, 1'b1);
    for (int i = 0; i < 3; i++) step(4'h0, 1'b1, 12'h135, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'h0, 1'b1, 12'h135, 1'b0);
      chk("stall_valid", {31'b0, v6}, 32'd1);
      chk("stall_data",  {24'b0, d6}, 32'h33);
    end
    for (int i = 0; i < 12; i++) step(4'h0, 1'b1, 12'h135, 1'b1);

    // Quarter pulses during a confirm message coalesce into one request.
    step(4'h0, 1'b0, 12'h000, 1'b1);
    xfer_log.delete();
    step(4'b0100, 1'b1, 12'h099, 1'b1);
    step(4'h0, 1'b1, 12'h099, 1'b1);
    for (int i = 0; i < 5; i++) step((i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1, 12'h099, 1'b1);
    for (int i = 0; i < 20; i++) step(4'h0, 1'b1, 12'h099, 1'b1);
    chk("coal_drop", {24'b0, c6}, 32'd2);
    chk("coal_len", xfer_log.size(), 32'd12);
    if (xfer_log.size() == 12) begin
      chk("coal_tag0", {24'b0, xfer_log[0]}, 32'h56);
      chk("coal_tag1", {24'b0, xfer_log[6]}, 32'h51);
    end

    // Hold a dime message stalled and hammer quarter until drop_cnt saturates.
    step(4'b0001, 1'b1, 12'h000, 1'b0);
    for (int i = 0; i < 300; i++) step(4'b0010, 1'b1, 12'h000, 1'b0);
    chk("drop_sat", {24'b0, c6}, 32'd255);
    for (int i = 0; i < 30; i++) step(4'h0, 1'b1, 12'h000, 1'b1);
    chk("drop_hold", {24'b0, c6}, 32'd255);

    // Balance changes after the tag must not reach the digits.
    xfer_log.delete();
    step(4'b0001, 1'b1, 12'h050, 1'b1);
    step(4'h0, 1'b1, 12'h050, 1'b1);
    for (int i = 0; i < 10; i++) step(4'h0, 1'b1, 12'h075, 1'b1);
    chk("snap_len", xfer_log.size(), 32'd6);
    if (xfer_log.size() == 6) begin
      chk("snap_d1", {24'b0, xfer_log[1]}, 32'h30);
      chk("snap_d2", {24'b0, xfer_log[2]}, 32'h35);
      chk("snap_d3", {24'b0, xfer_log[3]}, 32'h30);
    end

    // Reset mid-message at byte index 3 abandons it; a later dime is whole.
    step(4'b0001, 1'b1, 12'h123, 1'b1);
    for (int i = 0; i < 4; i++) step(4'h0, 1'b1, 12'h123, 1'b1);
    chk("pre_rst_data", {24'b0, d6}, 32'h33);
    step(4'b0010, 1'b0, 12'h123, 1'b1);
    chk("rst_valid", {31'b0, v6}, 32'd0);
    chk("rst_pend",  {28'b0, p6}, 32'd0);
    chk("rst_drop",  {24'b0, c6}, 32'd0);
    chk("rst_data",  {24'b0, d6}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(4'h0, 1'b1, 12'h123, 1'b1);
      chk("post_rst_idle", {31'b0, v6}, 32'd0);
    end
    xfer_log.delete();
    step(4'b0001, 1'b1, 12'h987, 1'b1);
    for (int i = 0; i < 10; i++) step(4'h0, 1'b1, 12'h987, 1'b1);
    chk("after_rst_len", xfer_log.size(), 32'd6);
    if (xfer_log.size() == 6) begin
      chk("after_rst_tag", {24'b0, xfer_log[0]}, 32'h44);
      chk("after_rst_lf",  {24'b0, xfer_log[5]}, 32'h0A);
    end

    // Random traffic against the model (both builds, including nibbles > 9).
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  ev;
      logic        rn;
      logic        rdy;
      logic [11:0] dab;
      for (int b = 0; b < 4; b++) ev[b] = ($urandom_range(0, 7) == 0);
      rn  = ($urandom_range(0, 499) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      dab = 12'($urandom);
      step(ev, rn, dab, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_msg_arbiter.md
Name: uart_msg_arbiter

Overview:
- Shares the single UART transmit byte channel among four vending-machine event requesters: give-change, confirm, quarter and dime.
- Latches one-cycle event pulses from the vending FSM into per-source pending flags and grants one source at a time by fixed priority.
- For each grant, snapshots the BCD balance and emits a multi-byte ASCII message over a valid/ready byte interface.
- Sits between the vending FSM / double-dabble output and the UART transmitter inside the UART driver.

Parameters:
- TAG_CHANGE, 8'h43, tag byte for a give-change message ('C').
- TAG_CONFIRM, 8'h56, tag byte for a confirm/vend message ('V').
- TAG_QUARTER, 8'h51, tag byte for a quarter message ('Q').
- TAG_DIME, 8'h44, tag byte for a dime message ('D').
- SEND_CRLF, 1, 1 = message ends with CR LF (6 bytes); 0 = no line ending (4 bytes).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- give_change  in  1  one-cycle event pulse.
- confirm_uart  in  1  one-cycle event pulse.
- quarter_uart  in  1  one-cycle event pulse.
- dime_uart  in  1  one-cycle event pulse.
- dabbled  in  12  balance in BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
- tx_ready  in  1  UART transmitter can accept a byte this cycle.
- tx_valid  out  1  tx_data holds a byte to transmit.
- tx_data  out  8  byte to transmit.
- busy  out  1  a message is in progress.
- grant  out  4  one-hot active source: [3] change, [2] confirm, [1] quarter, [0] dime.
- pending  out  4  latched request flags, same bit order as grant.
- drop_cnt  out  8  saturating count of coalesced (lost) events.

Behaviour:
- Reset: clk rising edge with reset=0 forces state=IDLE. tx_valid, busy, grant, pending, drop_cnt, byte index and the snapshot all go to 0, and tx_data goes to 8'h00. Reset takes effect in the same edge even mid-message; the partial message is abandoned and no further bytes are sent. Event pulses sampled while reset=0 are ignored.
- Request capture: an event at edge E sets its pending bit after E.
  - If the bit is already set and not being cleared at E, the event is coalesced and drop_cnt increments, saturating at 255.
  - Any combination of simultaneous events is captured, with one drop_cnt increment per coalesced source, summed in the same edge.
- States: IDLE, SEND.
- IDLE: if pending != 0 at edge E, pick the highest priority set bit (change > confirm > quarter > dime). At E:
  - set grant to that bit and clear that pending bit;
  - snapshot dabbled into a 12-bit register;
  - set byte index to 0 and enter SEND with tx_valid=1.
  - If the same source pulses at E, its pending bit stays set (new request, not a drop).
- SEND: tx_valid=1 and busy=1. tx_data is selected by the byte index:
  - 0 = tag of the granted source;
  - 1 = 8'h30 + snapshot[11:8];
  - 2 = 8'h30 + snapshot[7:4];
  - 3 = 8'h30 + snapshot[3:0];
  - 4 = 8'h0D;
  - 5 = 8'h0A.
  - There is no clamping of nibbles above 9.
- Transfer: a byte transfers on an edge where tx_valid=1 and tx_ready=1; the index then advances. tx_data is stable while tx_ready=0, with no timeout.
- Last byte (index 5, or 3 if SEND_CRLF=0): on its transfer, go to IDLE with tx_valid=0, busy=0, grant=0. IDLE lasts at least one cycle, so back-to-back messages are separated by a 1-cycle gap.
- Latency: event pulse in cycle N → pending visible in N+1 → tx_valid and tag byte visible in N+2 (if idle and highest priority).
- Snapshot isolation: dabbled changes during SEND do not affect the current message.
- Fixed priority may starve low sources under continuous high-priority traffic. This is acceptable at human button rates.

Decomposition:
- Package uart_msg_pkg:
  - state encoding (IDLE, SEND);
  - source index constants (SRC_CHANGE=3 … SRC_DIME=0);
  - ASCII constants (ASCII_ZERO 8'h30, ASCII_CR 8'h0D, ASCII_LF 8'h0A);
  - message length constants (6 and 4).
- One sub-module, prio_pick4: combinational 4-bit fixed-priority one-hot picker, bit 3 highest, output 0 when input 0.
- Byte formatting and the FSM stay inline.

Test Plan:
- Reset, dabbled=12'h135, quarter pulse, tx_ready=1 → two cycles later bytes 'Q','1','3','5',8'h0D,8'h0A in 6 consecutive cycles; grant=4'b0010 during send; busy falls after the last byte.
- Dime, quarter and give_change pulsed in the same cycle → messages in order 'C', 'Q', 'D', each separated by a 1-cycle IDLE; drop_cnt=0.
- tx_ready held 0 for 10 cycles mid-message at index 2 → tx_valid=1 and tx_data stable at tens digit throughout; sequence resumes unchanged when tx_ready returns.
- Three quarter pulses while a confirm message is sending → exactly one 'Q' message follows; drop_cnt=2. Then 300 coalesced pulses → drop_cnt saturates at 255.
- dabbled changed from 12'h050 to 12'h075 after the tag byte → digits sent '0','5','0'.
- reset=0 asserted at byte index 3 → next cycle tx_valid=0, pending=0, drop_cnt=0; no remaining bytes; new dime pulse afterward sends a full 'D' message. SEND_CRLF=0 build → 4-byte messages only.
